// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the pipelined RV32I core.
//
// Holds the PC, drives the asynchronous-read instruction memory address and
// captures the returned word into the IF/ID pipeline register. Later stages
// can stall it, redirect it (branch/jump resolution) or halt it. Halting is
// sticky until reset.
//
// Optional feature macro: IF_BTB_EN
//   defined   : direct-mapped BTB (BTB_ENTRIES entries) predicts the next PC
//   undefined : next PC is always pc+4 and btb_upd_* are ignored
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   imem_addr          instruction memory address (== pc, combinational)
//   imem_dout          instruction word for imem_addr, same cycle
//   stall              hold PC and IF/ID
//   redirect_valid/pc  correct next PC from EX (overrides stall)
//   halt_req           stop fetching permanently
//   btb_upd_valid/pc/target  BTB write port (resolved taken branch/jump)
//   if_id_*            IF/ID register: inst, pc, valid, pred_taken, pred_target
//   halted             fetch permanently stopped
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        btb_upd_valid,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target,
  output logic        halted
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        pred_taken;
    logic [31:0] pred_target;
  } if_id_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  if_id_t      if_id, if_id_nxt;
  logic        hit;
  logic [31:0] pred_next;

  assign imem_addr = pc;

`ifdef IF_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0]            btb_vld;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] btb_tag;
  logic [BTB_ENTRIES-1:0][31:0]      btb_tgt;
  logic [IDX_W-1:0]                  rd_idx, wr_idx;

  assign rd_idx = pc[IDX_W+1:2];
  assign wr_idx = btb_upd_pc[IDX_W+1:2];

  // Lookup reads the registered contents, so a same-cycle update to the
  // same index is only visible from the next cycle on.
  assign hit       = btb_vld[rd_idx] && (btb_tag[rd_idx] == pc[31:IDX_W+2]);
  assign pred_next = hit ? btb_tgt[rd_idx] : pc + 32'd4;

  // Updates are accepted in HALTED as well; only reset blocks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld <= '0;
    end else if (btb_upd_valid) begin
      btb_vld[wr_idx] <= 1'b1;
      btb_tag[wr_idx] <= btb_upd_pc[31:IDX_W+2];
      btb_tgt[wr_idx] <= btb_upd_target;
    end
  end

  wire unused_bits = ^{redirect_pc[1:0], btb_upd_pc[1:0]};
`else
  assign hit       = 1'b0;
  assign pred_next = pc + 32'd4;

  wire unused_bits = ^{redirect_pc[1:0], btb_upd_valid, btb_upd_pc,
                       btb_upd_target, BTB_ENTRIES > 1};
`endif

  // Next state / next PC / next IF/ID. Priority: halt > redirect > stall.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if_id_nxt = if_id;
    if (state == RUN) begin
      if (halt_req) begin
        state_nxt       = HALTED;
        if_id_nxt.inst  = NOP;
        if_id_nxt.valid = 1'b0;
      end else if (redirect_valid) begin
        pc_nxt          = {redirect_pc[31:2], 2'b00};
        if_id_nxt.inst  = NOP;
        if_id_nxt.valid = 1'b0;
      end else if (!stall) begin
        pc_nxt                = pred_next;
        if_id_nxt.inst        = imem_dout;
        if_id_nxt.pc          = pc;
        if_id_nxt.valid       = 1'b1;
        if_id_nxt.pred_taken  = hit;
        if_id_nxt.pred_target = pred_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      if_id <= '{inst: NOP, pc: '0, valid: 1'b0, pred_taken: 1'b0,
                 pred_target: '0};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if_id <= if_id_nxt;
    end
  end

  assign if_id_inst        = if_id.inst;
  assign if_id_pc          = if_id.pc;
  assign if_id_valid       = if_id.valid;
  assign if_id_pred_taken  = if_id.pred_taken;
  assign if_id_pred_target = if_id.pred_target;
  assign halted            = (state == HALTED);

endmodule
